// File: rtl/tick_gen_pkg.sv
// Shared encodings and the period helper for the tick_gen rate divider.
package tick_gen_pkg;

    localparam logic [1:0] SPD_FULL = 2'b00;
    localparam logic [1:0] SPD_1HZ  = 2'b01;
    localparam logic [1:0] SPD_HALF = 2'b10;
    localparam logic [1:0] SPD_QTR  = 2'b11;

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t RUN  = 1'b1;

    // Wide enough for 4*CLK_HZ-1 of any 32-bit clock rate; callers cast to CNT_W.
    localparam int PERIOD_W = 64;

    function automatic logic [PERIOD_W-1:0] period(input logic [1:0] speed,
                                                   input int unsigned clk_hz);
        logic [PERIOD_W-1:0] hz;
        hz = PERIOD_W'(clk_hz);
        case (speed)
            SPD_FULL: period = '0;
            SPD_1HZ:  period = hz - PERIOD_W'(1);
            SPD_HALF: period = (hz << 1) - PERIOD_W'(1);
            default:  period = (hz << 2) - PERIOD_W'(1);
        endcase
    endfunction

endpackage

// File: rtl/tick_gen_sync_edge.sv
// Two-flop synchroniser plus rising-edge detect for the step pushbutton.
// Only built when TICK_GEN_STEP_EN is defined.
`ifdef TICK_GEN_STEP_EN
module sync_edge (
    input  logic clk,
    input  logic clr,
    input  logic raw,
    output logic rise
);

    logic meta;
    logic stable;
    logic prev;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            meta   <= 1'b0;
            stable <= 1'b0;
            prev   <= 1'b0;
        end else begin
            meta   <= raw;
            stable <= meta;
            prev   <= stable;
        end
    end

    assign rise = stable & ~prev;

endmodule
`endif

// File: rtl/tick_gen.sv
// Rate divider producing a one-cycle tick at a switch-selected period.
// Define TICK_GEN_STEP_EN to enable single-step ticks from the pushbutton.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int          CNT_W  = 28
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       run,
    input  logic [1:0] speed,
    input  logic       step,
    output logic       tick
);

    localparam logic [CNT_W-1:0] LOAD_FULL = CNT_W'(period(SPD_FULL, CLK_HZ));
    localparam logic [CNT_W-1:0] LOAD_1HZ  = CNT_W'(period(SPD_1HZ, CLK_HZ));
    localparam logic [CNT_W-1:0] LOAD_HALF = CNT_W'(period(SPD_HALF, CLK_HZ));
    localparam logic [CNT_W-1:0] LOAD_QTR  = CNT_W'(period(SPD_QTR, CLK_HZ));

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       speed_q;
    logic             step_edge;

    function automatic logic [CNT_W-1:0] load_of(input logic [1:0] s);
        case (s)
            SPD_FULL: load_of = LOAD_FULL;
            SPD_1HZ:  load_of = LOAD_1HZ;
            SPD_HALF: load_of = LOAD_HALF;
            default:  load_of = LOAD_QTR;
        endcase
    endfunction

`ifdef TICK_GEN_STEP_EN
    sync_edge u_step (
        .clk  (clk),
        .clr  (clr),
        .raw  (step),
        .rise (step_edge)
    );
`else
    logic unused_step;
    assign unused_step = step;
    assign step_edge   = 1'b0;
`endif

    // A speed change restarts the period, so the old count is never finished.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= IDLE;
            cnt     <= '0;
            speed_q <= SPD_FULL;
            tick    <= 1'b0;
        end else if (state == IDLE) begin
            if (run) begin
                state   <= RUN;
                cnt     <= load_of(speed);
                speed_q <= speed;
                tick    <= 1'b0;
            end else begin
                tick <= step_edge;
            end
        end else begin
            if (!run) begin
                state <= IDLE;
                tick  <= 1'b0;
            end else if (speed != speed_q) begin
                speed_q <= speed;
                cnt     <= load_of(speed);
                tick    <= 1'b0;
            end else if (cnt == '0) begin
                tick <= 1'b1;
                cnt  <= load_of(speed_q);
            end else begin
                cnt  <= cnt - CNT_W'(1);
                tick <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tick_gen.sv
// Self-checking bench for tick_gen: vector table, corner sequences, random run vs model.
module tb_tick_gen;

    localparam int CLK_HZ = 4;
    localparam int CNT_W  = 6;
`ifdef TICK_GEN_STEP_EN
    localparam bit STEP_ON = 1'b1;
`else
    localparam bit STEP_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       run = 1'b0;
    logic [1:0] speed = 2'b00;
    logic       step = 1'b0;
    logic       tick;

    tick_gen #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .clr   (clr),
        .run   (run),
        .speed (speed),
        .step  (step),
        .tick  (tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit       run;
        bit [1:0] speed;
        bit       step;
        bit       exp;
    } vec_t;
    vec_t vecs[$];

    // Reference model: ticks fall on multiples of the period after the anchor edge.
    bit       m_running;
    int       m_anchor;
    int       m_per;
    bit [1:0] m_spd;
    int       m_k;
    bit       hist[$];

    function automatic int per_of(input bit [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return CLK_HZ;
            2'b10:   return 2 * CLK_HZ;
            default: return 4 * CLK_HZ;
        endcase
    endfunction

    task automatic model_reset();
        m_running = 1'b0;
        m_anchor  = 0;
        m_per     = 1;
        m_spd     = 2'b00;
        m_k       = 0;
        hist.delete();
        for (int i = 0; i < 4; i++) hist.push_back(1'b0);
    endtask

    task automatic model_edge(output bit e);
        bit press;
        hist.push_front(step);
        void'(hist.pop_back());
        press = STEP_ON && hist[2] && !hist[3];
        if (!m_running) begin
            if (run) begin
                m_running = 1'b1;
                m_anchor  = m_k;
                m_per     = per_of(speed);
                m_spd     = speed;
                e = 1'b0;
            end else begin
                e = press;
            end
        end else if (!run) begin
            m_running = 1'b0;
            e = 1'b0;
        end else if (speed != m_spd) begin
            m_anchor = m_k;
            m_per    = per_of(speed);
            m_spd    = speed;
            e = 1'b0;
        end else begin
            e = ((m_k - m_anchor) % m_per) == 0;
        end
        m_k++;
    endtask

    task automatic check(input string name, input bit exp);
        total++;
        if (tick !== exp) begin
            bad++;
            $display("FAIL %s: tick=%b required=%b (t=%0t)", name, tick, exp, $time);
        end
    endtask

    task automatic tcycle(input string name, input bit use_exp, input bit exp);
        bit mexp;
        @(posedge clk);
        model_edge(mexp);
        #1;
        check(name, use_exp ? exp : mexp);
    endtask

    task automatic do_reset();
        clr   = 1'b0;
        run   = 1'b0;
        speed = 2'b00;
        step  = 1'b0;
        @(posedge clk);
        #1;
        check("reset_tick", 1'b0);
        @(posedge clk);
        #1;
        clr = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();

        // run at speed 01, then stop; then speed 00 continuous, then stop
        for (int i = 0; i < 13; i++)
            vecs.push_back('{1'b1, 2'b01, 1'b0, (i == 4 || i == 8 || i == 12)});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 2'b00, 1'b0, 1'b0});
        for (int i = 0; i < 3; i++) vecs.push_back('{1'b1, 2'b00, 1'b0, 1'b1});
        for (int i = 0; i < 3; i++) vecs.push_back('{1'b0, 2'b00, 1'b0, 1'b0});

        do_reset();
        foreach (vecs[i]) begin
            run   = vecs[i].run;
            speed = vecs[i].speed;
            step  = vecs[i].step;
            tcycle($sformatf("vec%0d", i), 1'b1, vecs[i].exp);
        end

        // speed 11 running, switch to 10 five cycles in
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 22; i++) begin
            speed = (i < 5) ? 2'b11 : 2'b10;
            tcycle($sformatf("spdchg%0d", i), 1'b1, (i == 13 || i == 21));
        end

        // step held 20 cycles, release, press again
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            step = 1'b1;
            tcycle($sformatf("hold%0d", i), 1'b1, STEP_ON && i == 3);
        end
        for (int i = 1; i <= 4; i++) begin
            step = 1'b0;
            tcycle($sformatf("release%0d", i), 1'b1, 1'b0);
        end
        for (int i = 1; i <= 5; i++) begin
            step = 1'b1;
            tcycle($sformatf("repress%0d", i), 1'b1, STEP_ON && i == 3);
        end

        // step edge coincides with run start, then step toggles while running
        do_reset();
        step = 1'b1;
        tcycle("coin_e1", 1'b1, 1'b0);
        tcycle("coin_e2", 1'b1, 1'b0);
        run   = 1'b1;
        speed = 2'b11;
        tcycle("coin_e3", 1'b1, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            step = (i >= 4 && i < 10);
            tcycle($sformatf("runstep%0d", i), 1'b1, i == 16);
        end

        // asynchronous reset while tick is high
        do_reset();
        run   = 1'b1;
        speed = 2'b00;
        tcycle("full_start", 1'b1, 1'b0);
        tcycle("full_a", 1'b1, 1'b1);
        tcycle("full_b", 1'b1, 1'b1);
        #2 clr = 1'b0;
        #1 check("reset_async", 1'b0);
        speed = 2'b01;
        @(posedge clk);
        #1;
        check("reset_hold", 1'b0);
        clr = 1'b1;
        model_reset();
        for (int i = 0; i <= 8; i++)
            tcycle($sformatf("after_rst%0d", i), 1'b1, (i == 4 || i == 8));

        // randomized run against the reference model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) run = ~run;
            if ($urandom_range(0, 14) == 0) speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) step = ~step;
            tcycle($sformatf("rand%0d", i), 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
